// File: rtl/nitta_i2c_pkg.sv
// Shared definitions for the NITTA <-> I2C word/chunk converters.
// Both the serializer and the future assembler size their counters from these helpers.
package nitta_i2c_pkg;

   typedef enum logic {
      ORDER_LSB_FIRST = 1'b0,
      ORDER_MSB_FIRST = 1'b1
   } byte_order_e;

   function automatic int chunk_count(input int data_width, input int chunk_width);
      return data_width / chunk_width;
   endfunction

   // Width able to hold the value N itself, not just N-1.
   function automatic int cnt_width(input int data_width, input int chunk_width);
      return $clog2(chunk_count(data_width, chunk_width) + 1);
   endfunction

endpackage

// File: rtl/nitta_word_fifo.sv
// Small circular FIFO holding NITTA words together with their chunk counts.
module nitta_word_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FILL_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [FILL_W-1:0] fill;
   logic              do_push;
   logic              do_pop;

   function automatic logic [ADDR_W-1:0] bump(input logic [ADDR_W-1:0] ptr);
      return (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (fill == FILL_W'(DEPTH));
   assign empty   = (fill == '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         if (do_push && !do_pop)      fill <= fill + 1'b1;
         else if (do_pop && !do_push) fill <= fill - 1'b1;
      end
   end

   // Storage needs no reset: entries are only read once fill says they are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/nitta_to_i2c_serializer.sv
// Buffers NITTA words and hands them to the I2C byte engine one chunk per
// rising edge of the engine's ready level.
module nitta_to_i2c_serializer
   import nitta_i2c_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int CHUNK_WIDTH = 8,
   parameter int DEPTH       = 2,
   parameter int MSB_FIRST   = 1,
   localparam int N          = chunk_count(DATA_WIDTH, CHUNK_WIDTH),
   localparam int CNT_W      = cnt_width(DATA_WIDTH, CHUNK_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic [CNT_W-1:0]       in_chunks,
   output logic [CHUNK_WIDTH-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_next,
   output logic                   word_done,
   output logic                   busy
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam byte_order_e ORDER = (MSB_FIRST != 0) ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;

   logic [CNT_W-1:0]       push_count;
   logic [CNT_W-1:0]       head_count;
   logic [DATA_WIDTH-1:0]  head_data;
   logic [IDX_W-1:0]       idx;
   logic [CHUNK_WIDTH-1:0] chunk;
   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   logic                   next_q;
   logic                   next_edge;
   logic                   last_chunk;

   // A count of zero or anything beyond N means "send the whole word".
   assign push_count = (in_chunks == '0 || in_chunks > CNT_W'(N)) ? CNT_W'(N) : in_chunks;

   assign in_ready   = !full;
   assign push       = in_valid && !full;
   assign out_valid  = !empty;
   assign busy       = !empty;
   assign next_edge  = out_next && !next_q;
   assign last_chunk = (CNT_W'(idx) == head_count - CNT_W'(1));
   assign pop        = next_edge && out_valid && last_chunk;
   assign word_done  = pop;

   nitta_word_fifo #(
      .WIDTH(DATA_WIDTH + CNT_W),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (push),
      .pop    (pop),
      .wr_data({push_count, in_data}),
      .rd_data({head_count, head_data}),
      .full   (full),
      .empty  (empty)
   );

   // next_q resets high so a ready level held across reset release is not an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         next_q <= 1'b1;
         idx    <= '0;
      end else begin
         next_q <= out_next;
         if (next_edge && out_valid) idx <= last_chunk ? '0 : idx + 1'b1;
      end
   end

   if (ORDER == ORDER_MSB_FIRST) begin : g_msb_first
      assign chunk = head_data[DATA_WIDTH-1-int'(idx)*CHUNK_WIDTH -: CHUNK_WIDTH];
   end else begin : g_lsb_first
      assign chunk = head_data[int'(idx)*CHUNK_WIDTH +: CHUNK_WIDTH];
   end

   assign out_data = empty ? '0 : chunk;

endmodule

// File: tb/tb_nitta_to_i2c_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share stimulus, each with its own expected-chunk queue.
module tb_nitta_to_i2c_serializer;

   localparam int DW    = 32;
   localparam int CW    = 8;
   localparam int CNT_W = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid;
   logic [DW-1:0] in_data;
   logic [CNT_W-1:0] in_chunks;
   logic out_next;
   logic prev_next;

   logic m_in_ready, m_out_valid, m_word_done, m_busy;
   logic [CW-1:0] m_out_data;
   logic l_in_ready, l_out_valid, l_word_done, l_busy;
   logic [CW-1:0] l_out_data;

   typedef struct {
      logic [CW-1:0] data;
      logic          done;
   } exp_t;

   exp_t q_m[$];
   exp_t q_l[$];
   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   nitta_to_i2c_serializer #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW), .DEPTH(2), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_data(in_data),
      .in_chunks(in_chunks), .out_data(m_out_data), .out_valid(m_out_valid),
      .out_next(out_next), .word_done(m_word_done), .busy(m_busy)
   );

   nitta_to_i2c_serializer #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW), .DEPTH(2), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
      .in_chunks(in_chunks), .out_data(l_out_data), .out_valid(l_out_valid),
      .out_next(out_next), .word_done(l_word_done), .busy(l_busy)
   );

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total_cnt++;
      if (actual === expected) pass_cnt++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   // Engine-side view of the ready level, used to know when an edge is being presented.
   always @(posedge clk or negedge rst) begin
      if (!rst) prev_next <= 1'b1;
      else      prev_next <= out_next;
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (out_next && !prev_next && m_out_valid) begin
            if (q_m.size() == 0) begin
               total_cnt++;
               $display("[TB] FAIL msb_unexpected_chunk: got %0h, expected none", m_out_data);
            end else begin
               e = q_m.pop_front();
               check_output("msb_chunk", 32'(m_out_data), 32'(e.data));
               check_output("msb_word_done", 32'(m_word_done), 32'(e.done));
            end
         end else if (m_word_done) begin
            total_cnt++;
            $display("[TB] FAIL msb_spurious_word_done: got 1, expected 0");
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (out_next && !prev_next && l_out_valid) begin
            if (q_l.size() == 0) begin
               total_cnt++;
               $display("[TB] FAIL lsb_unexpected_chunk: got %0h, expected none", l_out_data);
            end else begin
               e = q_l.pop_front();
               check_output("lsb_chunk", 32'(l_out_data), 32'(e.data));
               check_output("lsb_word_done", 32'(l_word_done), 32'(e.done));
            end
         end else if (l_word_done) begin
            total_cnt++;
            $display("[TB] FAIL lsb_spurious_word_done: got 1, expected 0");
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_chunk(input logic [CW-1:0] msb_data, input logic [CW-1:0] lsb_data, input logic done);
      q_m.push_back('{data: msb_data, done: done});
      q_l.push_back('{data: lsb_data, done: done});
   endtask

   task automatic apply_stimulus(input logic [DW-1:0] data, input logic [CNT_W-1:0] chunks);
      int budget = 50;
      in_valid  = 1'b1;
      in_data   = data;
      in_chunks = chunks;
      while (!m_in_ready && budget > 0) begin
         tick(1);
         budget--;
      end
      if (budget == 0) begin
         total_cnt++;
         $display("[TB] FAIL push_timeout: got in_ready 0, expected 1");
      end
      tick(1);
      in_valid = 1'b0;
   endtask

   task automatic pulse_next();
      out_next = 1'b1;
      tick(1);
      out_next = 1'b0;
      tick(1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      in_valid  = 1'b0;
      in_data   = '0;
      in_chunks = '0;
      out_next  = 1'b1;
      rst       = 1'b0;
      tick(2);
      check_output("reset_in_ready", 32'(m_in_ready), 32'd1);
      check_output("reset_out_valid", 32'(m_out_valid), 32'd0);
      check_output("reset_out_data", 32'(m_out_data), 32'd0);
      check_output("reset_word_done", 32'(m_word_done), 32'd0);
      check_output("reset_busy", 32'(m_busy), 32'd0);
      check_output("reset_lsb_out_valid", 32'(l_out_valid), 32'd0);

      // Ready held high through reset release must not consume the first chunk.
      rst = 1'b1;
      tick(2);
      apply_stimulus(32'hA0B1C2D3, 3'd0);
      check_output("push_out_valid", 32'(m_out_valid), 32'd1);
      check_output("push_busy", 32'(m_busy), 32'd1);
      check_output("first_chunk_msb", 32'(m_out_data), 32'hA0);
      check_output("first_chunk_lsb", 32'(l_out_data), 32'hD3);
      tick(2);
      check_output("held_not_consumed", 32'(m_out_data), 32'hA0);
      out_next = 1'b0;
      tick(1);

      expect_chunk(8'hA0, 8'hD3, 1'b0);
      pulse_next();
      expect_chunk(8'hB1, 8'hC2, 1'b0);
      out_next = 1'b1;
      tick(4);
      out_next = 1'b0;
      tick(1);
      check_output("hold_once_msb", 32'(m_out_data), 32'hC2);
      check_output("hold_once_lsb", 32'(l_out_data), 32'hB1);
      expect_chunk(8'hC2, 8'hB1, 1'b0);
      pulse_next();
      expect_chunk(8'hD3, 8'hA0, 1'b1);
      pulse_next();
      check_output("drained_out_valid", 32'(m_out_valid), 32'd0);
      check_output("drained_out_data", 32'(m_out_data), 32'd0);
      check_output("drained_busy", 32'(l_busy), 32'd0);

      repeat (2) begin
         out_next = 1'b1;
         @(negedge clk);
         check_output("empty_edge_word_done", 32'(m_word_done), 32'd0);
         check_output("empty_edge_out_valid", 32'(m_out_valid), 32'd0);
         @(posedge clk);
         #1;
         out_next = 1'b0;
         tick(1);
      end

      apply_stimulus(32'h11223344, 3'd2);
      apply_stimulus(32'h55667788, 3'd2);
      check_output("full_in_ready", 32'(m_in_ready), 32'd0);
      expect_chunk(8'h11, 8'h44, 1'b0);
      expect_chunk(8'h22, 8'h33, 1'b1);
      expect_chunk(8'h55, 8'h88, 1'b0);
      expect_chunk(8'h66, 8'h77, 1'b1);
      pulse_next();
      check_output("still_full_in_ready", 32'(m_in_ready), 32'd0);
      pulse_next();
      check_output("after_pop_in_ready", 32'(m_in_ready), 32'd1);
      check_output("second_word_head", 32'(m_out_data), 32'h55);
      pulse_next();
      pulse_next();
      check_output("two_word_drained", 32'(m_out_valid), 32'd0);

      // Pop edge and held push collide while full: push must wait one cycle.
      apply_stimulus(32'h01020304, 3'd1);
      apply_stimulus(32'h05060708, 3'd1);
      expect_chunk(8'h01, 8'h04, 1'b1);
      expect_chunk(8'h05, 8'h08, 1'b1);
      expect_chunk(8'h09, 8'h0C, 1'b1);
      in_valid  = 1'b1;
      in_data   = 32'h090A0B0C;
      in_chunks = 3'd1;
      out_next  = 1'b1;
      @(negedge clk);
      check_output("collide_in_ready", 32'(m_in_ready), 32'd0);
      @(posedge clk);
      #1;
      out_next = 1'b0;
      check_output("collide_ready_after_pop", 32'(m_in_ready), 32'd1);
      check_output("collide_head", 32'(m_out_data), 32'h05);
      tick(1);
      in_valid = 1'b0;
      check_output("collide_refilled", 32'(m_in_ready), 32'd0);
      pulse_next();
      pulse_next();
      check_output("collide_drained", 32'(m_out_valid), 32'd0);

      apply_stimulus(32'hA0B1C2D3, 3'd0);
      expect_chunk(8'hA0, 8'hD3, 1'b0);
      expect_chunk(8'hB1, 8'hC2, 1'b0);
      pulse_next();
      pulse_next();
      rst = 1'b0;
      #1;
      check_output("midword_reset_out_valid", 32'(m_out_valid), 32'd0);
      check_output("midword_reset_out_data", 32'(m_out_data), 32'd0);
      check_output("midword_reset_word_done", 32'(m_word_done), 32'd0);
      check_output("midword_reset_lsb_valid", 32'(l_out_valid), 32'd0);
      tick(1);
      rst = 1'b1;
      tick(1);
      apply_stimulus(32'hCAFEBABE, 3'd0);
      check_output("restart_chunk_msb", 32'(m_out_data), 32'hCA);
      check_output("restart_chunk_lsb", 32'(l_out_data), 32'hBE);
      expect_chunk(8'hCA, 8'hBE, 1'b0);
      expect_chunk(8'hFE, 8'hBA, 1'b0);
      expect_chunk(8'hBA, 8'hFE, 1'b0);
      expect_chunk(8'hBE, 8'hCA, 1'b1);
      repeat (4) pulse_next();
      check_output("restart_drained", 32'(m_out_valid), 32'd0);

      tick(3);
      check_output("msb_queue_empty", 32'(q_m.size()), 32'd0);
      check_output("lsb_queue_empty", 32'(q_l.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
